// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the AES round datapath.
package aes_pkg;

    typedef logic [0:15][7:0] state_t;
    typedef logic [0:3][7:0]  col_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    // Low byte of the AES reduction polynomial 0x11B.
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns / InvMixColumns / bypass for one 4-byte column.
module mix_single_column
    import aes_pkg::*;
(
    input  col_t col_in,
    input  logic inverse,
    input  logic bypass,
    output col_t col_out
);

    col_t x2;
    col_t x4;
    col_t x8;

    for (genvar r = 0; r < 4; r++) begin : g_xt
        assign x2[r] = xtime(col_in[r]);
        assign x4[r] = xtime(x2[r]);
        assign x8[r] = xtime(x4[r]);
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        localparam logic [1:0] R0 = 2'(r);
        localparam logic [1:0] R1 = 2'((r + 1) % 4);
        localparam logic [1:0] R2 = 2'((r + 2) % 4);
        localparam logic [1:0] R3 = 2'((r + 3) % 4);

        logic [7:0] fwd;
        logic [7:0] inv;

        assign fwd = x2[R0] ^ x2[R1] ^ col_in[R1] ^ col_in[R2] ^ col_in[R3];
        // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
        assign inv = (x8[R0] ^ x4[R0] ^ x2[R0])
                   ^ (x8[R1] ^ x2[R1] ^ col_in[R1])
                   ^ (x8[R2] ^ x4[R2] ^ col_in[R2])
                   ^ (x8[R3] ^ col_in[R3]);

        assign col_out[r] = bypass ? col_in[r] : (inverse ? inv : fwd);
    end

endmodule

// File: rtl/mix_column_engine.sv
// Sequential MixColumns engine: accepts one state, transforms COLS_PER_CYCLE
// columns per clock in place, then holds the result until downstream takes it.
module mix_column_engine
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  logic   inverse,
    input  logic   bypass,
    input  state_t state_in,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t state_out,
    output logic   busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    fsm_t       fsm;
    logic [1:0] col_idx;
    logic       mode_inv;
    logic       mode_byp;
    logic       accept;

    col_t work    [4];
    col_t work_d  [4];
    col_t in_cols [4];
    col_t res     [COLS_PER_CYCLE];

    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == BUSY);
    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign state_out = {work[0], work[1], work[2], work[3]};

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        logic [1:0] sel;
        assign sel = col_idx + 2'(k);

        mix_single_column u_mix (
            .col_in  (work[sel]),
            .inverse (mode_inv),
            .bypass  (mode_byp),
            .col_out (res[k])
        );
    end

    // col_idx is always group-aligned, so column c belongs to lane c%COLS when
    // its group base matches col_idx.
    for (genvar c = 0; c < 4; c++) begin : g_col
        localparam int unsigned K    = c % COLS_PER_CYCLE;
        localparam logic [1:0]  BASE = 2'(c - K);

        assign in_cols[c] = state_in[4*c +: 4];
        assign work_d[c]  = (col_idx == BASE) ? res[K] : work[c];
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            fsm      <= IDLE;
            col_idx  <= '0;
            mode_inv <= 1'b0;
            mode_byp <= 1'b0;
            work     <= '{default: '0};
        end else if (accept) begin
            work     <= in_cols;
            mode_inv <= inverse;
            mode_byp <= bypass;
            col_idx  <= '0;
            fsm      <= BUSY;
        end else begin
            case (fsm)
                BUSY: begin
                    work    <= work_d;
                    col_idx <= col_idx + STEP;
                    if (col_idx == LAST) begin
                        fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_column_engine.sv
// Bench for mix_column_engine: one instance per COLS_PER_CYCLE value, each
// checked every cycle against a GF(2^8) reference model plus literal vectors.
module tb_mix_column_engine;
    import aes_pkg::*;

    localparam state_t FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam state_t FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam state_t D5_IN   = 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6;
    localparam state_t D4_OUT  = 128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5;
    localparam state_t BYP_IN  = 128'h2d26314c_2d26314c_2d26314c_2d26314c;

    logic clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    function automatic void check(string name, int cols, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [cols=%0d] got %h expected %h", name, cols, act, exp);
        end
    endfunction

    function automatic void check_bit(string name, int cols, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [cols=%0d] got %b expected %b", name, cols, act, exp);
        end
    endfunction

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'(9'h11B) << (i - 8);
        return p[7:0];
    endfunction

    function automatic state_t model(state_t s, logic inv, logic byp);
        logic [7:0] m [4];
        state_t     r;
        logic [7:0] acc;
        if (byp) return s;
        if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc ^= gmul(m[2'(j - row)], s[4'(4 * c + j)]);
                r[4'(4 * c + row)] = acc;
            end
        end
        return r;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int C = 1 << g;
        localparam int N = 4 / C;

        typedef struct {
            state_t exp;
            int     acc;
        } item_t;

        logic   n_rst, in_valid, in_ready, inverse, bypass, out_valid, out_ready, busy;
        state_t state_in, state_out;
        item_t  q[$];
        int     cyc = 0;
        bit     run = 1'b0;

        mix_column_engine #(.COLS_PER_CYCLE(C)) u_dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .inverse   (inverse),
            .bypass    (bypass),
            .state_in  (state_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .state_out (state_out),
            .busy      (busy)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // acc is the index of the accept edge; cyc at a negedge is the last edge index.
        always @(negedge clk) begin
            logic accepted, ev, eb, er;
            if (run) begin
                accepted = (q.size() > 0) && (cyc >= q[0].acc);
                ev = accepted && (cyc >= q[0].acc + N);
                eb = accepted && (cyc < q[0].acc + N);
                er = !accepted || (ev && out_ready);
                check_bit("out_valid", C, out_valid, ev);
                check_bit("busy", C, busy, eb);
                check_bit("in_ready", C, in_ready, er);
                if (ev && out_valid) begin
                    check("state_out", C, state_out, q[0].exp);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end

        task automatic tick;
            @(posedge clk);
            #1;
        endtask

        task automatic send(state_t s, logic inv, logic byp, bit rnd, output int waited);
            state_in = s;
            inverse  = inv;
            bypass   = byp;
            in_valid = 1'b1;
            waited   = 0;
            @(negedge clk);
            while (!in_ready && waited <= 100) begin
                waited++;
                if (rnd) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
            end
            if (!in_ready) begin
                check_bit("send_accept_timeout", C, in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            q.push_back('{exp: model(s, inv, byp), acc: cyc + 1});
            tick();
            in_valid = 1'b0;
            state_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            inverse  = 1'($urandom());
            bypass   = 1'($urandom());
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        endtask

        task automatic wait_out(output state_t r);
            int t = 0;
            @(negedge clk);
            while (!out_valid && t < 100) begin
                t++;
                @(negedge clk);
            end
            if (!out_valid) check_bit("wait_out_timeout", C, out_valid, 1'b1);
            r = state_out;
        endtask

        task automatic release_out;
            tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        endtask

        initial begin
            state_t r, r2, s;
            int     w, t;
            n_rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            inverse = 1'b0; bypass = 1'b0; state_in = '0;
            repeat (2) tick();
            n_rst = 1'b1;
            run   = 1'b1;
            @(negedge clk);
            check_bit("rst_out_valid", C, out_valid, 1'b0);
            check_bit("rst_busy", C, busy, 1'b0);
            check_bit("rst_in_ready", C, in_ready, 1'b1);
            check("rst_state_out", C, state_out, '0);

            tick();
            send(FWD_IN, 1'b0, 1'b0, 1'b0, w);
            wait_out(r);
            check("fwd_vector", C, r, FWD_OUT);
            repeat (5) begin
                @(negedge clk);
                check_bit("hold_out_valid", C, out_valid, 1'b1);
                check_bit("hold_in_ready", C, in_ready, 1'b0);
                check("hold_state_out", C, state_out, FWD_OUT);
            end

            tick();
            out_ready = 1'b1;
            send(FWD_OUT, 1'b1, 1'b0, 1'b0, w);
            check("b2b_same_edge", C, 128'(w), 128'(0));
            out_ready = 1'b0;
            wait_out(r);
            check("inv_vector", C, r, FWD_IN);
            release_out();

            send(D5_IN, 1'b1, 1'b0, 1'b0, w);
            wait_out(r);
            check("inv_d5", C, r, D4_OUT);
            release_out();

            send(BYP_IN, 1'b1, 1'b1, 1'b0, w);
            wait_out(r);
            check("bypass_vector", C, r, BYP_IN);
            release_out();

            // Reset lands on the second BUSY edge; the block must vanish.
            send(FWD_IN, 1'b0, 1'b0, 1'b0, w);
            tick();
            n_rst = 1'b0;
            run   = 1'b0;
            tick();
            q.delete();
            n_rst = 1'b1;
            run   = 1'b1;
            @(negedge clk);
            check_bit("midrst_out_valid", C, out_valid, 1'b0);
            check_bit("midrst_in_ready", C, in_ready, 1'b1);
            check("midrst_state_out", C, state_out, '0);
            repeat (10) tick();

            for (int i = 0; i < 1000; i++) begin
                s = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(s, 1'($urandom()), 1'($urandom()), 1'b1, w);
            end
            out_ready = 1'b1;
            t = 0;
            while (q.size() != 0 && t < 200) begin
                tick();
                t++;
            end
            check("stream_drain", C, 128'(q.size()), 128'(0));
            out_ready = 1'b0;
            tick();

            for (int i = 0; i < 50; i++) begin
                s = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(s, 1'b0, 1'b0, 1'b0, w);
                wait_out(r);
                release_out();
                send(r, 1'b1, 1'b0, 1'b0, w);
                wait_out(r2);
                check("roundtrip", C, r2, s);
                release_out();
            end
            done_cnt++;
        end
    end

    initial begin
        int t = 0;
        check("model_fwd", 0, model(FWD_IN, 1'b0, 1'b0), FWD_OUT);
        check("model_inv", 0, model(FWD_OUT, 1'b1, 1'b0), FWD_IN);
        check("model_inv_d5", 0, model(D5_IN, 1'b1, 1'b0), D4_OUT);
        while (done_cnt < 3 && t < 300000) begin
            @(posedge clk);
            t++;
        end
        if (done_cnt < 3) check("global_timeout", 0, 128'(done_cnt), 128'(3));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_column_engine.md
# mix_column_engine

Sequential, parametrised MixColumns engine for the AES datapath, sitting between the shift-rows stage and add-round-key in the round controller. It accepts one 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It supports forward MixColumns (encrypt), inverse MixColumns (decrypt), and bypass (final round). The result is held until the downstream stage accepts it.

## Interface
- COLS_PER_CYCLE, 1: columns processed per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  input  1  system clock. All logic is on the rising edge.
- n_rst  input  1  reset, synchronous and active-low.
- in_valid  input  1  upstream has a state on state_in.
- in_ready  output  1  engine can accept a state this cycle.
- inverse  input  1  1 selects InvMixColumns. Sampled on accept.
- bypass  input  1  1 passes the state unchanged. Takes priority over inverse. Sampled on accept.
- state_in  input  [0:15][7:0]  input state. Byte 4c+r is row r of column c.
- out_valid  output  1  state_out holds a finished result.
- out_ready  input  1  downstream accepts state_out this cycle.
- state_out  output  [0:15][7:0]  result, in the same byte ordering as state_in.
- busy  output  1  high while in BUSY.

## Operation
- Define N = 4/COLS_PER_CYCLE.
- Internal registers:
  - a 128-bit working state register;
  - a column index col_idx, width 2 bits;
  - registered copies of mode (inverse, bypass).
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, load state_in and mode, clear col_idx, go to BUSY.
  - BUSY: each edge replaces columns col_idx .. col_idx+COLS_PER_CYCLE-1 in place with their transform. col_idx then increments by COLS_PER_CYCLE, wrapping mod 4. The edge that processes column 3 goes to DONE.
  - DONE: out_valid=1 and state_out = working register.
    - On out_ready with in_valid low: go to IDLE.
    - On out_ready with in_valid high: load the new block and mode, go to BUSY (back-to-back accept).
    - With out_ready low: hold. state_out stays stable.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from out_ready. No other input-to-output combinational path exists.
- Forward transform, per column with bytes s0..s3: r0 = 2·s0 ^ 3·s1 ^ s2 ^ s3, rotated for each row (matches FIPS-197).
- Inverse transform, per column: r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3, rotated for each row.
- Arithmetic:
  - All multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1B : 0).
  - Higher constants are built from xtime chains and XOR only. No lookup tables.
- Bypass: the BUSY cycles still elapse and the columns are rewritten unchanged. Latency does not depend on mode.
- Inputs inverse, bypass and state_in are ignored except on the accept edge.

## Timing
- Accept edge E0: in_valid && in_ready.
- out_valid rises after edge E0+N:
  - COLS_PER_CYCLE=1: 4 cycles;
  - COLS_PER_CYCLE=2: 2 cycles;
  - COLS_PER_CYCLE=4: 1 cycle.
- Peak throughput with out_ready held high: one block per N+1 cycles, because the DONE cycle overlaps the next accept.
- Reset, when n_rst is low at an edge:
  - FSM goes to IDLE. col_idx=0. Working register and mode registers are cleared.
  - Outputs after reset: out_valid=0, busy=0, state_out=0, in_ready=1.
  - Reset takes effect from any state, including mid-BUSY. The in-flight block is discarded and no out_valid pulse is produced for it.
- in_valid in BUSY: ignored and not latched. The upstream stage holds it.
- out_ready while not in DONE: ignored.

## Structure
- Package aes_pkg holds:
  - typedef state_t = logic [0:15][7:0];
  - typedef col_t = logic [0:3][7:0];
  - FSM enum {IDLE, BUSY, DONE};
  - function xtime;
  - constant 8'h1B.
- Sub-module mix_single_column: combinational.
  - Inputs: col_t col_in, inverse, bypass.
  - Output: col_t col_out.
  - The engine instantiates it COLS_PER_CYCLE times via generate.
  - Instance k is fed column col_idx+k.

## Test plan
- Forward, each COLS_PER_CYCLE in {1,2,4}:
  - Stimulus: column 0 = db 13 53 45, column 1 = f2 0a 22 5c, column 2 = 01 01 01 01, column 3 = c6 c6 c6 c6.
  - Required output: 8e 4d a1 bc / 9f dc 58 9d / 01 01 01 01 / c6 c6 c6 c6.
  - out_valid must rise exactly N cycles after accept.
- Inverse: feed the forward result above with inverse=1. Required output is the original columns (db 13 53 45 etc.). Also cover d5 d5 d7 d6 -> d4 d4 d4 d5.
- Bypass: bypass=1 and inverse=1 with column 2d 26 31 4c repeated in all four columns. state_out must equal state_in after the same N-cycle latency.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE: state_out and out_valid must stay stable, and in_ready must stay 0.
  - Then raise out_ready with in_valid=1: the next block is accepted on that same edge.
- Reset mid-operation: drive n_rst=0 on the second BUSY cycle with COLS_PER_CYCLE=1. Next cycle: IDLE, out_valid=0, state_out=0, in_ready=1. No stale result may appear afterwards.
- Randomised: 1000 random states with random modes, for all three COLS_PER_CYCLE values. Compare against a reference model, and check that forward followed by inverse returns the original state.
